// File: rtl/mul_share_pkg.sv
// Shared constants and control-state encoding for the multiplier-sharing arbiter.
package mul_share_pkg;

    localparam int DW      = 8;
    localparam int MUL_LAT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb.sv
// Round-robin one-hot arbiter: first set request at or above ptr, wrapping to bit 0.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant
);

    logic [NREQ-1:0] hi_mask;
    logic [NREQ-1:0] req_hi;
    logic [NREQ-1:0] pick_src;

    // Requests at or above ptr win; only when none exist does the search wrap to bit 0.
    assign hi_mask  = ~((NREQ'(1) << ptr) - NREQ'(1));
    assign req_hi   = req & hi_mask;
    assign pick_src = (|req_hi) ? req_hi : req;
    assign grant    = en ? (pick_src & (~pick_src + NREQ'(1))) : '0;

endmodule

// File: rtl/mul_share_arb.sv
// Shares one pipelined multiplier among NREQ requesters: round-robin launch,
// id tagging alongside the multiplier latency, and response steering.
module mul_share_arb #(
    parameter int NREQ    = 4,
    parameter int DW      = mul_share_pkg::DW,
    parameter int MUL_LAT = mul_share_pkg::MUL_LAT,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    output logic [NREQ-1:0]    req_ready,
    output logic               mul_en_in,
    output logic [DW-1:0]      mul_a,
    output logic [DW-1:0]      mul_b,
    input  logic               mul_en_out,
    input  logic [2*DW-1:0]    mul_out,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [2*DW-1:0]    rsp_data,
    output logic               busy,
    output logic               tag_err
);
    import mul_share_pkg::*;

    state_t             state_reg, state_next;
    logic               arb_en;
    logic [IDW-1:0]     ptr_reg;
    logic [NREQ-1:0]    grant;
    logic               handshake;
    logic [IDW-1:0]     grant_id;
    logic [DW-1:0]      opa [NREQ];
    logic [DW-1:0]      opb [NREQ];
    logic               launch_v_reg;
    logic [IDW-1:0]     launch_id_reg;
    logic [DW-1:0]      launch_a_reg, launch_b_reg;
    logic [MUL_LAT-1:0] tag_v_reg;
    logic [IDW-1:0]     tag_id_reg [MUL_LAT];
    logic               tail_v;
    logic [IDW-1:0]     tail_id;
    logic               rsp_hit;
    logic [NREQ-1:0]    rsp_sel;
    logic [NREQ-1:0]    rsp_valid_reg;
    logic [2*DW-1:0]    rsp_data_reg;
    logic               tag_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign opa[gi] = req_a[gi*DW +: DW];
            assign opb[gi] = req_b[gi*DW +: DW];
        end
    endgenerate

    rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_rr_arb (
        .req   (req_valid),
        .ptr   (ptr_reg),
        .en    (arb_en),
        .grant (grant)
    );

    // The arbiter only grants asserted requests, so any grant is a handshake.
    assign handshake = |grant;

    always_comb begin
        grant_id = '0;
        for (int k = 0; k < NREQ; k++)
            if (grant[k]) grant_id = IDW'(k);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Re-enabling during drain takes priority over returning to idle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (en) state_next = RUN;
            RUN:     if (!en) state_next = busy ? DRAIN : IDLE;
            DRAIN:   if (en) state_next = RUN;
                     else if (!busy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb arb_en = en && (state_reg == RUN);

    assign tail_v  = tag_v_reg[MUL_LAT-1];
    assign tail_id = tag_id_reg[MUL_LAT-1];
    assign rsp_hit = mul_en_out && tail_v;

    always_comb begin
        rsp_sel          = '0;
        rsp_sel[tail_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg       <= '0;
            launch_v_reg  <= 1'b0;
            launch_id_reg <= '0;
            launch_a_reg  <= '0;
            launch_b_reg  <= '0;
            tag_v_reg     <= '0;
            for (int k = 0; k < MUL_LAT; k++) tag_id_reg[k] <= '0;
            rsp_valid_reg <= '0;
            rsp_data_reg  <= '0;
            tag_err_reg   <= 1'b0;
        end else begin
            if (handshake)
                ptr_reg <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
            launch_v_reg  <= handshake;
            launch_id_reg <= grant_id;
            launch_a_reg  <= handshake ? opa[grant_id] : '0;
            launch_b_reg  <= handshake ? opb[grant_id] : '0;
            // Tag pipe tail lines up with the multiplier's result strobe.
            tag_v_reg     <= {tag_v_reg[MUL_LAT-2:0], launch_v_reg};
            tag_id_reg[0] <= launch_id_reg;
            for (int k = 1; k < MUL_LAT; k++) tag_id_reg[k] <= tag_id_reg[k-1];
            rsp_valid_reg <= rsp_hit ? rsp_sel : '0;
            rsp_data_reg  <= rsp_hit ? mul_out : '0;
            if (mul_en_out != tail_v) tag_err_reg <= 1'b1;
        end
    end

    assign req_ready = grant;
    assign mul_en_in = launch_v_reg;
    assign mul_a     = launch_a_reg;
    assign mul_b     = launch_b_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign tag_err   = tag_err_reg;
    assign busy      = launch_v_reg | (|tag_v_reg) | (|rsp_valid_reg);

endmodule

// File: tb/tb_mul_share_arb.sv
// Randomized and directed bench for mul_share_arb with a behavioural 4-cycle multiplier.
module tb_mul_share_arb;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*DW-1:0] req_a = '0;
    logic [NREQ*DW-1:0] req_b = '0;
    logic [NREQ-1:0]    req_ready;
    logic               mul_en_in;
    logic [DW-1:0]      mul_a, mul_b;
    logic               mul_en_out;
    logic [2*DW-1:0]    mul_out;
    logic [NREQ-1:0]    rsp_valid;
    logic [2*DW-1:0]    rsp_data;
    logic               busy, tag_err;

    int n_pass = 0;
    int n_checks = 0;

    mul_share_arb dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_en_in(mul_en_in), .mul_a(mul_a), .mul_b(mul_b),
        .mul_en_out(mul_en_out), .mul_out(mul_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: product appears exactly 4 cycles after the launch strobe.
    logic [3:0]  mp_v;
    logic [15:0] mp_p [4];
    logic        inject = 1'b0;
    logic [15:0] inject_data = 16'h1234;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mp_v <= '0;
            for (int k = 0; k < 4; k++) mp_p[k] <= '0;
        end else begin
            mp_v    <= {mp_v[2:0], mul_en_in};
            mp_p[0] <= {8'h00, mul_a} * {8'h00, mul_b};
            for (int k = 1; k < 4; k++) mp_p[k] <= mp_p[k-1];
        end
    end
    assign mul_en_out = mp_v[3] | inject;
    assign mul_out    = mp_v[3] ? mp_p[3] : (inject ? inject_data : 16'h0000);

    // Reference model: arbitration mode, rotating pointer, handshake history, expected responses.
    int              m_state;      // 0 idle, 1 running, 2 draining
    int              m_ptr;
    int              cyc = 0;
    int              last_hs;
    logic            m_lv;
    logic [7:0]      m_la, m_lb;
    logic [NREQ-1:0] exp_v [64];
    logic [15:0]     exp_d [64];

    function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
        return {8'h00, a} * {8'h00, b};
    endfunction

    function automatic logic [NREQ-1:0] model_grant();
        logic [NREQ-1:0] g;
        int j;
        g = '0;
        if (en && m_state == 1) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (m_ptr + k) % NREQ;
                if (req_valid[IDW'(j)]) begin
                    g[IDW'(j)] = 1'b1;
                    break;
                end
            end
        end
        return g;
    endfunction

    // An operation keeps the block busy from its launch cycle through its response cycle.
    function automatic bit model_busy();
        return (cyc - last_hs >= 1) && (cyc - last_hs <= 6);
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_ptr   = 0;
        last_hs = -100;
        m_lv    = 1'b0;
        m_la    = '0;
        m_lb    = '0;
        for (int k = 0; k < 64; k++) begin
            exp_v[k] = '0;
            exp_d[k] = '0;
        end
    endtask

    task automatic drive(input logic e, input logic [3:0] v, input logic [31:0] a, input logic [31:0] b);
        en        = e;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        #1;
    endtask

    task automatic advance();
        logic [NREQ-1:0] g;
        bit              bz;
        logic            nl_v;
        logic [7:0]      nl_a, nl_b;
        g    = model_grant();
        bz   = model_busy();
        nl_v = 1'b0;
        nl_a = '0;
        nl_b = '0;
        exp_v[6'(cyc)] = '0;
        exp_d[6'(cyc)] = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (g[k]) begin
                nl_v = 1'b1;
                nl_a = req_a[k*DW +: DW];
                nl_b = req_b[k*DW +: DW];
                exp_v[6'(cyc + 6)] = g;
                exp_d[6'(cyc + 6)] = prod(nl_a, nl_b);
                m_ptr   = (k + 1) % NREQ;
                last_hs = cyc;
            end
        end
        case (m_state)
            0: if (en) m_state = 1;
            1: if (!en) m_state = bz ? 2 : 0;
            default: if (en) m_state = 1; else if (!bz) m_state = 0;
        endcase
        @(posedge clk);
        cyc++;
        #1;
        m_lv = nl_v;
        m_la = nl_a;
        m_lb = nl_b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        #2;
        n_checks++; if (req_ready !== 4'b0) $display("FAIL reset_req_ready got=%b want=0000", req_ready); else n_pass++;
        n_checks++; if ({mul_en_in, mul_a, mul_b} !== 17'b0) $display("FAIL reset_launch got=%b/%h/%h want=0/00/00", mul_en_in, mul_a, mul_b); else n_pass++;
        n_checks++; if (rsp_valid !== 4'b0 || rsp_data !== 16'h0) $display("FAIL reset_rsp got=%b/%h want=0000/0000", rsp_valid, rsp_data); else n_pass++;
        n_checks++; if (busy !== 1'b0 || tag_err !== 1'b0) $display("FAIL reset_flags got busy=%b tag_err=%b want 0/0", busy, tag_err); else n_pass++;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_round_robin();
        int          cnt [NREQ];
        logic [3:0]  one = 4'b0001;
        logic [3:0]  want;
        for (int k = 0; k < NREQ; k++) cnt[k] = 0;
        drive(1'b1, 4'h0, 32'h0, 32'h0);
        advance();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, (i < 8) ? 4'hF : 4'h0, {4{8'h03}}, {4{8'h05}});
            want = (i < 8) ? (one << (i % 4)) : 4'b0000;
            n_checks++; if (req_ready !== want) $display("FAIL rr_grant step=%0d got=%b want=%b", i, req_ready, want); else n_pass++;
            n_checks++; if (rsp_valid !== exp_v[6'(cyc)]) $display("FAIL rr_rsp_valid step=%0d got=%b want=%b", i, rsp_valid, exp_v[6'(cyc)]); else n_pass++;
            if (|rsp_valid) begin
                n_checks++; if (rsp_data !== 16'h000F) $display("FAIL rr_rsp_data step=%0d got=%h want=000f", i, rsp_data); else n_pass++;
            end
            for (int k = 0; k < NREQ; k++) cnt[k] += int'(rsp_valid[k]);
            advance();
        end
        for (int k = 0; k < NREQ; k++) begin
            n_checks++; if (cnt[k] != 2) $display("FAIL rr_count req=%0d got=%0d want=2", k, cnt[k]); else n_pass++;
        end
    endtask

    task automatic test_single_op();
        drive(1'b1, 4'b0100, 32'h00FF_0000, 32'h00FF_0000);
        n_checks++; if (req_ready !== 4'b0100) $display("FAIL single_grant got=%b want=0100", req_ready); else n_pass++;
        advance();
        for (int j = 1; j <= 7; j++) begin
            drive(1'b1, 4'h0, 32'h0, 32'h0);
            if (j == 1) begin
                n_checks++; if ({mul_en_in, mul_a, mul_b} !== {1'b1, 8'hFF, 8'hFF}) $display("FAIL single_launch got=%b/%h/%h want=1/ff/ff", mul_en_in, mul_a, mul_b); else n_pass++;
            end
            n_checks++; if (rsp_valid !== ((j == 6) ? 4'b0100 : 4'b0000)) $display("FAIL single_rsp_valid j=%0d got=%b", j, rsp_valid); else n_pass++;
            if (j == 6) begin
                n_checks++; if (rsp_data !== 16'hFE01) $display("FAIL single_rsp_data got=%h want=fe01", rsp_data); else n_pass++;
            end
            advance();
        end
    endtask

    task automatic test_wrap_skip();
        logic [3:0] want;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, (i < 3) ? 4'b1010 : 4'b0000, $urandom(), $urandom());
            want = (i == 1) ? 4'b0010 : ((i == 0 || i == 2) ? 4'b1000 : 4'b0000);
            n_checks++; if (req_ready !== want) $display("FAIL wrap_grant step=%0d got=%b want=%b", i, req_ready, want); else n_pass++;
            n_checks++; if (rsp_valid !== exp_v[6'(cyc)] || rsp_data !== exp_d[6'(cyc)]) $display("FAIL wrap_rsp step=%0d got=%b/%h want=%b/%h", i, rsp_valid, rsp_data, exp_v[6'(cyc)], exp_d[6'(cyc)]); else n_pass++;
            advance();
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] g;
        for (int i = 0; i < 88; i++) begin
            drive((i >= 80) || ($urandom_range(0, 7) != 0), (i < 80) ? 4'($urandom_range(0, 15)) : 4'h0, $urandom(), $urandom());
            g = model_grant();
            n_checks++; if (req_ready !== g) $display("FAIL rand_grant cyc=%0d got=%b want=%b", cyc, req_ready, g); else n_pass++;
            n_checks++; if ({mul_en_in, mul_a, mul_b} !== {m_lv, m_la, m_lb}) $display("FAIL rand_launch cyc=%0d got=%b/%h/%h want=%b/%h/%h", cyc, mul_en_in, mul_a, mul_b, m_lv, m_la, m_lb); else n_pass++;
            n_checks++; if (rsp_valid !== exp_v[6'(cyc)] || rsp_data !== exp_d[6'(cyc)]) $display("FAIL rand_rsp cyc=%0d got=%b/%h want=%b/%h", cyc, rsp_valid, rsp_data, exp_v[6'(cyc)], exp_d[6'(cyc)]); else n_pass++;
            n_checks++; if (busy !== model_busy()) $display("FAIL rand_busy cyc=%0d got=%b want=%b", cyc, busy, model_busy()); else n_pass++;
            advance();
        end
    endtask

    task automatic test_drain();
        logic [NREQ-1:0] g;
        int n_rsp = 0;
        int last_rsp = -1;
        int idle_at = -1;
        drive(1'b1, 4'h0, 32'h0, 32'h0);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'hF, $urandom(), $urandom());
            g = model_grant();
            n_checks++; if (req_ready !== g || g == 4'b0) $display("FAIL drain_fill_grant step=%0d got=%b want=%b", i, req_ready, g); else n_pass++;
            advance();
        end
        for (int i = 0; i < 20 && idle_at < 0; i++) begin
            drive(1'b0, 4'hF, $urandom(), $urandom());
            n_checks++; if (req_ready !== 4'b0) $display("FAIL drain_ready step=%0d got=%b want=0000", i, req_ready); else n_pass++;
            n_checks++; if (rsp_valid !== exp_v[6'(cyc)] || rsp_data !== exp_d[6'(cyc)]) $display("FAIL drain_rsp step=%0d got=%b/%h want=%b/%h", i, rsp_valid, rsp_data, exp_v[6'(cyc)], exp_d[6'(cyc)]); else n_pass++;
            n_checks++; if (busy !== model_busy()) $display("FAIL drain_busy step=%0d got=%b want=%b", i, busy, model_busy()); else n_pass++;
            if (|rsp_valid) begin
                n_rsp++;
                last_rsp = cyc;
            end
            if (busy === 1'b0) idle_at = cyc;
            advance();
        end
        n_checks++; if (n_rsp != 3) $display("FAIL drain_rsp_count got=%0d want=3", n_rsp); else n_pass++;
        n_checks++; if (idle_at != last_rsp + 1) $display("FAIL drain_busy_drop got=%0d want=%0d", idle_at, last_rsp + 1); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 4'h0, 32'h0, 32'h0);
            advance();
        end
        drive(1'b1, 4'b0001, 32'h0000_0007, 32'h0000_0009);
        n_checks++; if (req_ready !== 4'b0000) $display("FAIL drain_idle_first got=%b want=0000", req_ready); else n_pass++;
        advance();
        drive(1'b1, 4'b0001, 32'h0000_0007, 32'h0000_0009);
        n_checks++; if (req_ready !== 4'b0001) $display("FAIL drain_rerun_grant got=%b want=0001", req_ready); else n_pass++;
        advance();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 4'h0, 32'h0, 32'h0);
            n_checks++; if (rsp_valid !== exp_v[6'(cyc)] || rsp_data !== exp_d[6'(cyc)]) $display("FAIL drain_flush_rsp step=%0d got=%b/%h want=%b/%h", i, rsp_valid, rsp_data, exp_v[6'(cyc)], exp_d[6'(cyc)]); else n_pass++;
            advance();
        end
    endtask

    task automatic test_error();
        inject = 1'b1;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        n_checks++; if (tag_err !== 1'b0) $display("FAIL err_before got=%b want=0", tag_err); else n_pass++;
        advance();
        inject = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'h0, 32'h0, 32'h0);
            n_checks++; if (tag_err !== 1'b1) $display("FAIL err_sticky step=%0d got=%b want=1", i, tag_err); else n_pass++;
            n_checks++; if (rsp_valid !== 4'b0) $display("FAIL err_no_rsp step=%0d got=%b want=0000", i, rsp_valid); else n_pass++;
            advance();
        end
    endtask

    task automatic test_reset_midstream();
        logic [3:0] want;
        drive(1'b1, 4'h0, 32'h0, 32'h0);
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'hF, $urandom(), $urandom());
            advance();
        end
        rst_n = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'b0) $display("FAIL midrst_req_ready got=%b want=0000", req_ready); else n_pass++;
        n_checks++; if ({mul_en_in, mul_a, mul_b} !== 17'b0) $display("FAIL midrst_launch got=%b/%h/%h want=0/00/00", mul_en_in, mul_a, mul_b); else n_pass++;
        n_checks++; if (rsp_valid !== 4'b0 || rsp_data !== 16'h0) $display("FAIL midrst_rsp got=%b/%h want=0000/0000", rsp_valid, rsp_data); else n_pass++;
        n_checks++; if (busy !== 1'b0 || tag_err !== 1'b0) $display("FAIL midrst_flags got busy=%b tag_err=%b want 0/0", busy, tag_err); else n_pass++;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, (i < 2) ? 4'hF : 4'h0, 32'h0B0A_0908, 32'h0403_0201);
            want = (i == 1) ? 4'b0001 : 4'b0000;
            n_checks++; if (req_ready !== want) $display("FAIL midrst_grant step=%0d got=%b want=%b", i, req_ready, want); else n_pass++;
            n_checks++; if (rsp_valid !== exp_v[6'(cyc)] || rsp_data !== exp_d[6'(cyc)]) $display("FAIL midrst_rsp_after step=%0d got=%b/%h want=%b/%h", i, rsp_valid, rsp_data, exp_v[6'(cyc)], exp_d[6'(cyc)]); else n_pass++;
            n_checks++; if (tag_err !== 1'b0) $display("FAIL midrst_tag_err step=%0d got=%b want=0", i, tag_err); else n_pass++;
            advance();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_round_robin();
        test_single_op();
        test_wrap_skip();
        test_random();
        test_drain();
        test_error();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
